mac_accumulator: RTL and testbench

//  Downstream consumer of the N-bit adder/multiplier top stage. Accepts one {prod, cout} beat
//  per valid/ready handshake and accumulates LEN products into a wide register. Counts adder

---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_accumulator_if.sv | 33 +++
 rtl/mac_acc_add.sv | 32 +++
 rtl/mac_accumulator.sv | 152 +++++++++++++++
 tb/tb_mac_accumulator.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC accumulator slice.
// The optional saturating accumulator is selected with the MAC_SAT_EN macro.
package mac_pkg;

  // Two-state frame FSM: collecting beats, or holding a finished result
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Default accumulator width: wide enough that LEN full-scale products never overflow
  function automatic int acc_w_default(input int n, input int len);
    return 2 * n + $clog2(len);
  endfunction

  // Default counter width: must hold the value LEN itself
  // so that the carry counter can never wrap
  function automatic int cnt_w_default(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Beat input and result output handshakes of the MAC accumulator.
// The slave modport is the accumulator's view.
// The master modport is the surrounding system: the upstream stage plus the downstream consumer.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int N     = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = acc_w_default(N, LEN),
  parameter int CNT_W = cnt_w_default(LEN)
);

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_prod;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_ccnt;
  logic             out_sat;

  modport slave (
    input  in_valid, in_prod, in_cout, out_ready,
    output in_ready, out_valid, out_acc, out_ccnt, out_sat
  );

  modport master (
    output in_valid, in_prod, in_cout, out_ready,
    input  in_ready, out_valid, out_acc, out_ccnt, out_sat
  );

endinterface

// File: rtl/mac_acc_add.sv
// Combinational accumulator adder.
// With MAC_SAT_EN defined, an overflowing sum clamps to all-ones and ovf reports the clamp.
// Without MAC_SAT_EN, the sum wraps modulo 2^ACC_W and no carry or compare logic exists.
module mac_acc_add #(
  parameter int ACC_W = 11
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum
`ifdef MAC_SAT_EN
  ,
  output logic             ovf
`endif
);

`ifdef MAC_SAT_EN
  logic [ACC_W:0] wide;

  // Add with one guard bit; a set guard bit means the true sum is out of range, so clamp
  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    ovf  = wide[ACC_W];
    sum  = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
  end
`else
  // Plain modular add; any carry out of the top bit is simply lost
  always_comb begin
    sum = a + b;
  end
`endif

endmodule

// File: rtl/mac_accumulator.sv
// MAC accumulator.
// Sums LEN unsigned products per frame and counts the beats that carried an adder carry-out.
// Each finished frame's result is held on a registered valid/ready output.
// Optional feature macro: MAC_SAT_EN selects a saturating accumulator with a sticky out_sat flag.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N     = 4,
  parameter int LEN   = 8,
  parameter int ACC_W = acc_w_default(N, LEN),
  parameter int CNT_W = cnt_w_default(LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  mac_accumulator_if.slave bus
);

  state_e           state;
  state_e           state_next;
  logic             in_rdy;
  logic             out_vld;
  logic             accept;
  logic             last_beat;
  logic [2*N-1:0]   prod_in;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] beat;
  logic [CNT_W-1:0] ccnt;
  logic [CNT_W-1:0] ccnt_next;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_ccnt_q;

`ifdef MAC_SAT_EN
  logic             add_ovf;
  logic             sat_flag;
  logic             out_sat_q;
`endif

  assign prod_in   = bus.in_prod;
  assign prod_ext  = ACC_W'(prod_in);
  // Readiness is purely a function of state, so accept does not depend on the comb FSM block
  assign accept    = bus.in_valid & (state == ST_ACC);
  assign last_beat = (beat == CNT_W'(LEN - 1));
  assign ccnt_next = ccnt + CNT_W'(bus.in_cout);

  mac_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (acc_sum)
`ifdef MAC_SAT_EN
    ,
    .ovf (add_ovf)
`endif
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; clr forces a return to collecting a fresh frame
  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    out_vld    = 1'b0;
    case (state)
      ST_ACC: begin
        in_rdy = 1'b1;
        if (bus.in_valid && last_beat) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_vld = 1'b1;
        if (bus.out_ready) begin
          state_next = ST_ACC;
        end
      end
      default: begin
        state_next = ST_ACC;
      end
    endcase
    if (clr) begin
      state_next = ST_ACC;
    end
  end

  // Frame accumulation, counters, and capture of the finished result on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      beat       <= '0;
      ccnt       <= '0;
      out_acc_q  <= '0;
      out_ccnt_q <= '0;
    end else if (clr) begin
      acc  <= '0;
      beat <= '0;
      ccnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        out_acc_q  <= acc_sum;
        out_ccnt_q <= ccnt_next;
        acc        <= '0;
        beat       <= '0;
        ccnt       <= '0;
      end else begin
        acc  <= acc_sum;
        beat <= beat + 1'b1;
        ccnt <= ccnt_next;
      end
    end
  end

`ifdef MAC_SAT_EN
  // Sticky per-frame saturation flag, copied to out_sat together with the frame result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag  <= 1'b0;
      out_sat_q <= 1'b0;
    end else if (clr) begin
      sat_flag  <= 1'b0;
      out_sat_q <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        out_sat_q <= sat_flag | add_ovf;
        sat_flag  <= 1'b0;
      end else begin
        sat_flag  <= sat_flag | add_ovf;
      end
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  assign bus.out_sat = 1'b0;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ccnt  = out_ccnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed testbench for mac_accumulator.
// Uses N=4 and LEN=8, plus a second instance with ACC_W=8 for the overflow case.
// Expected overflow results follow MAC_SAT_EN when it is defined for the build.
module tb_mac_accumulator;

  logic clk;
  logic rst_n;
  logic clr;
  int   tests_run;
  int   tests_failed;

  mac_accumulator_if #(.N(4), .LEN(8), .ACC_W(11), .CNT_W(4)) bus ();
  mac_accumulator_if #(.N(4), .LEN(8), .ACC_W(8),  .CNT_W(4)) bus8 ();

  mac_accumulator #(.N(4), .LEN(8), .ACC_W(11), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  mac_accumulator #(.N(4), .LEN(8), .ACC_W(8), .CNT_W(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge: presents one beat across the next rising edge, returns at the following falling edge
  task automatic drive_beat(input logic [7:0] p, input logic c);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_cout  = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_prod   = 8'($urandom);
      bus.in_cout   = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus8.in_valid = 1'($urandom);
      bus8.in_prod  = 8'($urandom);
      clr           = 1'($urandom);
      @(negedge clk);
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
      tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_in_ready: got %0b expected 1", bus.in_ready); end
    end
    tests_run++; if (bus.out_acc !== 11'd0) begin tests_failed++; $display("[TB] FAIL rst_out_acc: got %0d expected 0", bus.out_acc); end
    tests_run++; if (bus.out_ccnt !== 4'd0) begin tests_failed++; $display("[TB] FAIL rst_out_ccnt: got %0d expected 0", bus.out_ccnt); end
    tests_run++; if (bus.out_sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_out_sat: got %0b expected 0", bus.out_sat); end
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_cout   = 1'b0;
    bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in_prod  = '0;
    clr           = 1'b0;
    rst_n         = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_out_valid: got %0b expected 0", bus.out_valid); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 8; i++) drive_beat(8'd225, (i % 2) == 0);
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_out_valid: got %0b expected 1", bus.out_valid); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_in_ready: got %0b expected 0", bus.in_ready); end
    tests_run++; if (bus.out_acc !== 11'd1800) begin tests_failed++; $display("[TB] FAIL basic_out_acc: got %0d expected 1800", bus.out_acc); end
    tests_run++; if (bus.out_ccnt !== 4'd4) begin tests_failed++; $display("[TB] FAIL basic_out_ccnt: got %0d expected 4", bus.out_ccnt); end
    tests_run++; if (bus.out_sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_out_sat: got %0b expected 0", bus.out_sat); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_release_valid: got %0b expected 0", bus.out_valid); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_release_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_bubbles_hold();
    for (int i = 0; i < 8; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        bus.in_valid = 1'b0;
        bus.in_prod  = 8'($urandom);
        bus.in_cout  = 1'($urandom);
        @(negedge clk);
      end
      drive_beat(8'd225, (i % 2) == 0);
    end
    // Junk beats are offered throughout the hold and must all be refused
    for (int h = 0; h < 5; h++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = 8'd99;
      bus.in_cout  = 1'b1;
      tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_out_valid[%0d]: got %0b expected 1", h, bus.out_valid); end
      tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_in_ready[%0d]: got %0b expected 0", h, bus.in_ready); end
      tests_run++; if (bus.out_acc !== 11'd1800) begin tests_failed++; $display("[TB] FAIL hold_out_acc[%0d]: got %0d expected 1800", h, bus.out_acc); end
      tests_run++; if (bus.out_ccnt !== 4'd4) begin tests_failed++; $display("[TB] FAIL hold_out_ccnt[%0d]: got %0d expected 4", h, bus.out_ccnt); end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) begin
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_accept_once: got %0b expected 0", bus.out_valid); end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) drive_beat(8'd3, 1'b1);
    tests_run++; if (bus.out_acc !== 11'd24) begin tests_failed++; $display("[TB] FAIL next_out_acc: got %0d expected 24", bus.out_acc); end
    tests_run++; if (bus.out_ccnt !== 4'd8) begin tests_failed++; $display("[TB] FAIL next_out_ccnt: got %0d expected 8", bus.out_ccnt); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_clear();
    logic [7:0] pattern;
    pattern = 8'b0100_1001;
    for (int i = 0; i < 3; i++) drive_beat(8'd10, 1'b1);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 8'd10;
    bus.in_cout  = 1'b1;
    @(negedge clk);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL clr_out_valid: got %0b expected 0", bus.out_valid); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_in_ready: got %0b expected 1", bus.in_ready); end
    for (int i = 0; i < 8; i++) drive_beat(8'd1, pattern[i]);
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL clr_frame_valid: got %0b expected 1", bus.out_valid); end
    tests_run++; if (bus.out_acc !== 11'd8) begin tests_failed++; $display("[TB] FAIL clr_out_acc: got %0d expected 8", bus.out_acc); end
    tests_run++; if (bus.out_ccnt !== 4'd3) begin tests_failed++; $display("[TB] FAIL clr_out_ccnt: got %0d expected 3", bus.out_ccnt); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) drive_beat(8'd2, 1'b0);
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL arst_pre_valid: got %0b expected 1", bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_out_valid: got %0b expected 0", bus.out_valid); end
    tests_run++; if (bus.out_acc !== 11'd0) begin tests_failed++; $display("[TB] FAIL arst_out_acc: got %0d expected 0", bus.out_acc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) drive_beat(8'd5, 1'b1);
    tests_run++; if (bus.out_acc !== 11'd40) begin tests_failed++; $display("[TB] FAIL arst_next_acc: got %0d expected 40", bus.out_acc); end
    tests_run++; if (bus.out_ccnt !== 4'd8) begin tests_failed++; $display("[TB] FAIL arst_next_ccnt: got %0d expected 8", bus.out_ccnt); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_acc;
    logic       exp_sat;
`ifdef MAC_SAT_EN
    exp_acc = 8'd255;
    exp_sat = 1'b1;
`else
    exp_acc = 8'd64;
    exp_sat = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_prod  = 8'd200;
      bus8.in_cout  = 1'b0;
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
    tests_run++; if (bus8.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_out_valid: got %0b expected 1", bus8.out_valid); end
    tests_run++; if (bus8.out_acc !== exp_acc) begin tests_failed++; $display("[TB] FAIL ovf_out_acc: got %0d expected %0d", bus8.out_acc, exp_acc); end
    tests_run++; if (bus8.out_sat !== exp_sat) begin tests_failed++; $display("[TB] FAIL ovf_out_sat: got %0b expected %0b", bus8.out_sat, exp_sat); end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    tests_run++; if (bus8.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_release_valid: got %0b expected 0", bus8.out_valid); end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    clr            = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_prod    = '0;
    bus.in_cout    = 1'b0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_prod   = '0;
    bus8.in_cout   = 1'b0;
    bus8.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_bubbles_hold();
    test_clear();
    test_async_reset();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
